// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter in front of a single 64-bit data memory.
// A granted access is checked for alignment and range, then either rejected
// straight away or run through ISSUE -> WAIT -> DONE with a fixed memory latency.
module data_memory_arbiter #(
    parameter int MEM_SIZE = 1024,
    parameter int LATENCY  = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        Write0,
    input  logic [63:0] Addr0,
    input  logic [63:0] WData0,
    input  logic        Req1,
    input  logic        Write1,
    input  logic [63:0] Addr1,
    input  logic [63:0] WData1,
    output logic        Ack0,
    output logic        Err0,
    output logic [63:0] RData0,
    output logic        Ack1,
    output logic        Err1,
    output logic [63:0] RData1,
    output logic [63:0] MemAddress,
    output logic [63:0] MemWriteData,
    output logic        MemoryRead,
    output logic        MemoryWrite,
    input  logic [63:0] MemReadData,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // Highest legal doubleword address; compared at full width so Addr+7 never wraps.
    localparam logic [63:0] MAX_ADDR = 64'(MEM_SIZE - 8);
    localparam logic [3:0]  WAIT_CYCLES = 4'(LATENCY);

    state_t      state_q, state_d;
    logic        rrPtr_q, rrPtr_d;
    logic        grant_q, grant_d;
    logic        write_q, write_d;
    logic [3:0]  count_q, count_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic [63:0] rdata0_q, rdata0_d;
    logic [63:0] rdata1_q, rdata1_d;
    logic [63:0] memAddr_q, memAddr_d;
    logic [63:0] memWData_q, memWData_d;
    logic        memRead_q, memRead_d;
    logic        memWrite_q, memWrite_d;
    logic        busy_q, busy_d;

    logic        reqAny;
    logic        grantSel;
    logic        selWrite;
    logic [63:0] selAddr;
    logic [63:0] selWData;
    logic        selBad;

    // Pick the requester to serve this cycle and decide whether its access is legal.
    always_comb begin
        reqAny   = Req0 | Req1;
        grantSel = (Req0 && Req1) ? rrPtr_q : Req1;
        selWrite = grantSel ? Write1 : Write0;
        selAddr  = grantSel ? Addr1  : Addr0;
        selWData = grantSel ? WData1 : WData0;
        selBad   = (selAddr[2:0] != 3'b000) || (selAddr > MAX_ADDR);
    end

    // Next state and next value of every registered output; pulses default low.
    always_comb begin
        state_d    = state_q;
        rrPtr_d    = rrPtr_q;
        grant_d    = grant_q;
        write_d    = write_q;
        count_d    = count_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        memAddr_d  = 64'd0;
        memWData_d = 64'd0;
        memRead_d  = 1'b0;
        memWrite_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (reqAny) begin
                    grant_d = grantSel;
                    write_d = selWrite;
                    if (selBad) begin
                        state_d = DONE;
                        ack0_d  = ~grantSel;
                        ack1_d  = grantSel;
                        err0_d  = ~grantSel;
                        err1_d  = grantSel;
                    end else begin
                        state_d    = ISSUE;
                        memRead_d  = ~selWrite;
                        memWrite_d = selWrite;
                        memAddr_d  = selAddr;
                        memWData_d = selWData;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                count_d = WAIT_CYCLES;
            end
            WAIT: begin
                if (count_q <= 4'd1) begin
                    state_d = DONE;
                    count_d = 4'd0;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    if (!write_q) begin
                        if (grant_q) begin
                            rdata1_d = MemReadData;
                        end else begin
                            rdata0_d = MemReadData;
                        end
                    end
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                rrPtr_d = ~grant_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset wins over any transition in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            rrPtr_q    <= 1'b0;
            grant_q    <= 1'b0;
            write_q    <= 1'b0;
            count_q    <= 4'd0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= 64'd0;
            rdata1_q   <= 64'd0;
            memAddr_q  <= 64'd0;
            memWData_q <= 64'd0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rrPtr_q    <= rrPtr_d;
            grant_q    <= grant_d;
            write_q    <= write_d;
            count_q    <= count_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            memAddr_q  <= memAddr_d;
            memWData_q <= memWData_d;
            memRead_q  <= memRead_d;
            memWrite_q <= memWrite_d;
            busy_q     <= busy_d;
        end
    end

    assign Ack0         = ack0_q;
    assign Ack1         = ack1_q;
    assign Err0         = err0_q;
    assign Err1         = err1_q;
    assign RData0       = rdata0_q;
    assign RData1       = rdata1_q;
    assign MemAddress   = memAddr_q;
    assign MemWriteData = memWData_q;
    assign MemoryRead   = memRead_q;
    assign MemoryWrite  = memWrite_q;
    assign Busy         = busy_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter (MEM_SIZE 1024, LATENCY 2) with a
// small registered-read memory model behind the arbiter.
module tb_data_memory_arbiter;

    logic        Clock;
    logic        Reset;
    logic        Req0, Write0, Req1, Write1;
    logic [63:0] Addr0, WData0, Addr1, WData1;
    logic        Ack0, Err0, Ack1, Err1;
    logic [63:0] RData0, RData1;
    logic [63:0] MemAddress, MemWriteData, MemReadData;
    logic        MemoryRead, MemoryWrite, Busy;

    int testsRun = 0;
    int failures = 0;
    int readPulses = 0;
    int writePulses = 0;
    int strayOutputs = 0;
    logic [63:0] lastStrobeAddr = 64'd0;
    logic [63:0] lastStrobeWData = 64'd0;

    logic [63:0] mem [0:127];
    logic [63:0] memRdReg;

    int cycles;
    int nAcks;
    int collide;
    int ackOrder [4];
    int ackCycle [4];

    data_memory_arbiter #(.MEM_SIZE(1024), .LATENCY(2)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0), .Write0(Write0), .Addr0(Addr0), .WData0(WData0),
        .Req1(Req1), .Write1(Write1), .Addr1(Addr1), .WData1(WData1),
        .Ack0(Ack0), .Err0(Err0), .RData0(RData0),
        .Ack1(Ack1), .Err1(Err1), .RData1(RData1),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
        .MemReadData(MemReadData), .Busy(Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory model: read data registered on the strobe and held through WAIT.
    always @(posedge Clock) begin
        if (MemoryWrite === 1'b1) mem[MemAddress[9:3]] <= MemWriteData;
        if (MemoryRead === 1'b1) memRdReg <= mem[MemAddress[9:3]];
    end
    assign MemReadData = memRdReg;

    // Strobe counting and bus-idle watching.
    always @(posedge Clock) begin
        if (MemoryRead === 1'b1) readPulses++;
        if (MemoryWrite === 1'b1) writePulses++;
        if (MemoryRead === 1'b1 || MemoryWrite === 1'b1) begin
            lastStrobeAddr  = MemAddress;
            lastStrobeWData = MemWriteData;
        end
        if (!Reset && MemoryRead === 1'b0 && MemoryWrite === 1'b0 &&
            (MemAddress !== 64'd0 || MemWriteData !== 64'd0)) strayOutputs++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic wr,
                                 input logic [63:0] addr, input logic [63:0] wdata);
        if (port == 0) begin
            Req0 = req; Write0 = wr; Addr0 = addr; WData0 = wdata;
        end else begin
            Req1 = req; Write1 = wr; Addr1 = addr; WData1 = wdata;
        end
    endtask

    // Counts negedges from the request edge until the port acks (bounded).
    task automatic waitAck(input int port, output int n);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!((port == 0) ? Ack0 : Ack1) && n < 20);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 64'd0;
        mem[3]   = 64'h0ffbea7deadbeeff;
        mem[127] = 64'hcafef00d000003f8;
        memRdReg = 64'd0;
        Reset = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        applyStimulus(1, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checkOutput("reset_acks", {60'd0, Ack0, Ack1, Err0, Err1}, 64'd0);
        checkOutput("reset_rdata0", RData0, 64'd0);
        checkOutput("reset_rdata1", RData1, 64'd0);
        checkOutput("reset_bus", {MemAddress | MemWriteData}, 64'd0);
        checkOutput("reset_strobes_busy", {61'd0, MemoryRead, MemoryWrite, Busy}, 64'd0);
        Reset = 1'b0;

        // Load on port 0.
        readPulses = 0; writePulses = 0;
        applyStimulus(0, 1'b1, 1'b0, 64'h18, 64'd0);
        @(negedge Clock);
        checkOutput("load0_issue", {62'd0, MemoryRead, Busy}, 64'd3);
        checkOutput("load0_issue_addr", MemAddress, 64'h18);
        cycles = 1;
        waitAck(0, cycles);
        checkOutput("load0_latency", 64'(cycles + 1), 64'd4);
        checkOutput("load0_rdata", RData0, 64'h0ffbea7deadbeeff);
        checkOutput("load0_err", {63'd0, Err0}, 64'd0);
        checkOutput("load0_pulses", {32'(readPulses), 32'(writePulses)}, {32'd1, 32'd0});
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge Clock);
        checkOutput("load0_back_idle", {62'd0, Busy, Ack0}, 64'd0);

        // Store on port 1, then read it back through port 0.
        readPulses = 0; writePulses = 0;
        applyStimulus(1, 1'b1, 1'b1, 64'h28, 64'h1234);
        waitAck(1, cycles);
        checkOutput("store1_latency", 64'(cycles), 64'd4);
        checkOutput("store1_pulses", {32'(readPulses), 32'(writePulses)}, {32'd0, 32'd1});
        checkOutput("store1_addr", lastStrobeAddr, 64'h28);
        checkOutput("store1_wdata", lastStrobeWData, 64'h1234);
        checkOutput("store1_err_rdata", {Err1, RData1[62:0]}, 64'd0);
        applyStimulus(1, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge Clock);
        applyStimulus(0, 1'b1, 1'b0, 64'h28, 64'd0);
        waitAck(0, cycles);
        checkOutput("load0_after_store", RData0, 64'h1234);
        checkOutput("rdata1_unchanged", RData1, 64'd0);
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge Clock);

        // Rejected addresses: misaligned, past end, and a value that would wrap.
        readPulses = 0; writePulses = 0;
        applyStimulus(0, 1'b1, 1'b0, 64'h1c, 64'd0);
        waitAck(0, cycles);
        checkOutput("rej_1c_latency", 64'(cycles), 64'd1);
        checkOutput("rej_1c_err", {63'd0, Err0}, 64'd1);
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge Clock);
        checkOutput("rej_1c_clear", {62'd0, Ack0, Err0}, 64'd0);
        applyStimulus(0, 1'b1, 1'b1, 64'h3fc, 64'h55);
        waitAck(0, cycles);
        checkOutput("rej_3fc_latency", 64'(cycles), 64'd1);
        checkOutput("rej_3fc_err", {63'd0, Err0}, 64'd1);
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge Clock);
        applyStimulus(0, 1'b1, 1'b0, 64'h400, 64'd0);
        waitAck(0, cycles);
        checkOutput("rej_400_err", {62'd0, 1'(cycles == 1), Err0}, 64'd3);
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge Clock);
        applyStimulus(0, 1'b1, 1'b0, 64'hfffffffffffffff8, 64'd0);
        waitAck(0, cycles);
        checkOutput("rej_wrap_err", {62'd0, 1'(cycles == 1), Err0}, 64'd3);
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge Clock);
        checkOutput("rej_no_strobe", {32'(readPulses), 32'(writePulses)}, 64'd0);
        checkOutput("rej_rdata0_kept", RData0, 64'h1234);

        // Last legal doubleword is accepted.
        applyStimulus(0, 1'b1, 1'b0, 64'h3f8, 64'd0);
        waitAck(0, cycles);
        checkOutput("edge_3f8_latency", 64'(cycles), 64'd4);
        checkOutput("edge_3f8_err", {63'd0, Err0}, 64'd0);
        checkOutput("edge_3f8_rdata", RData0, 64'hcafef00d000003f8);
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge Clock);

        // Reset during WAIT of a load abandons it.
        applyStimulus(0, 1'b1, 1'b0, 64'h18, 64'd0);
        @(negedge Clock);
        @(negedge Clock);
        checkOutput("rst_in_wait_busy", {63'd0, Busy}, 64'd1);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        checkOutput("rst_mid_outputs", {61'd0, Ack0, Busy, MemoryRead}, 64'd0);
        checkOutput("rst_mid_rdata0", RData0, 64'd0);
        @(negedge Clock);
        checkOutput("rst_mid_no_ack", {62'd0, Ack0, Busy}, 64'd0);
        applyStimulus(0, 1'b1, 1'b0, 64'h18, 64'd0);
        waitAck(0, cycles);
        checkOutput("post_rst_latency", 64'(cycles), 64'd4);
        checkOutput("post_rst_rdata", RData0, 64'h0ffbea7deadbeeff);
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge Clock);

        // Both ports requesting continuously from reset: grants alternate.
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin ackOrder[i] = -1; ackCycle[i] = -1; end
        nAcks = 0; collide = 0;
        applyStimulus(0, 1'b1, 1'b0, 64'h18, 64'd0);
        applyStimulus(1, 1'b1, 1'b0, 64'h28, 64'd0);
        for (int c = 1; c <= 60 && nAcks < 4; c++) begin
            @(negedge Clock);
            if (Ack0 && Ack1) collide++;
            if (Ack0 || Ack1) begin
                ackOrder[nAcks] = Ack1 ? 1 : 0;
                ackCycle[nAcks] = c;
                nAcks++;
            end
        end
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        applyStimulus(1, 1'b0, 1'b0, 64'd0, 64'd0);
        checkOutput("rr_ack_count", 64'(nAcks), 64'd4);
        checkOutput("rr_collisions", 64'(collide), 64'd0);
        checkOutput("rr_first_ack_cycle", 64'(ackCycle[0]), 64'd4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("rr_grant_%0d", i), 64'(ackOrder[i]), 64'(i % 2));
        for (int i = 1; i < 4; i++)
            checkOutput($sformatf("rr_spacing_%0d", i), 64'(ackCycle[i] - ackCycle[i-1]), 64'd5);
        checkOutput("rr_rdata0", RData0, 64'h0ffbea7deadbeeff);
        checkOutput("rr_rdata1", RData1, 64'h1234);
        @(negedge Clock);
        checkOutput("bus_idle_outside_issue", 64'(strayOutputs), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
